// File: rtl/transmissor_display_pkg.sv
// Shared definitions for the parity-protected 7-segment display link.
// The display decoder imports the same parity helper so both ends agree.
package transmissor_display_pkg;

    localparam int CODE_W       = 5;
    localparam int MAX_CODE_DEF = 20;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Odd parity: E plus P always carry an odd number of ones.
    function automatic logic odd_parity(input logic [CODE_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/fifo_codigos.sv
// Synchronous code FIFO. Pointers carry an extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module fifo_codigos
    import transmissor_display_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CODE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; a write on the reset edge is orphaned by the pointer clear.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/transmissor_display.sv
// Transmitter for the display link: buffers producer codes, launches each
// as an (E, P) frame and holds it for HOLD_CYCLES cycles.
module transmissor_display
    import transmissor_display_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_CODE    = MAX_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inject_err,
    output logic [CODE_W-1:0] E,
    output logic              P,
    output logic              frame_strobe,
    output logic              busy,
    output logic              dropped
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    logic [0:0]        state;
    logic [CW-1:0]     cnt;
    logic              full;
    logic              empty;
    logic [CODE_W-1:0] head;
    logic              accept;
    logic              code_ok;
    logic              launch;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign code_ok  = (int'(in_code) <= MAX_CODE);

    // A frame ends when the counter reaches zero; a queued code follows with no gap.
    assign launch = !empty && ((state == ST_IDLE) || (cnt == '0));
    assign busy   = (state == ST_HOLD) || !empty;

    fifo_codigos #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && code_ok),
        .wdata (in_code),
        .pop   (launch),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            E            <= '0;
            P            <= 1'b1;
            frame_strobe <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            frame_strobe <= launch;
            dropped      <= accept && !code_ok;
            if (launch) begin
                E     <= head;
                P     <= odd_parity(head) ^ inject_err;
                cnt   <= HOLD_LOAD;
                state <= ST_HOLD;
            end else if (state == ST_HOLD) begin
                if (cnt == '0)
                    state <= ST_IDLE;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_transmissor_display.sv
// Bench for transmissor_display: directed table, multi-cycle sequences and
// randomized traffic checked against a queue-based timing model.
module tb_transmissor_display;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int MAXC  = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic       inject_err;
    logic [4:0] E;
    logic       P;
    logic       frame_strobe;
    logic       busy;
    logic       dropped;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    transmissor_display #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .MAX_CODE(MAXC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_code      (in_code),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inject_err   (inject_err),
        .E            (E),
        .P            (P),
        .frame_strobe (frame_strobe),
        .busy         (busy),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    // Model: queue of stored codes plus the age (in edges) of the frame on display.
    int   mq[$];
    bit   m_active;
    int   m_age;
    int   m_e;
    bit   m_p, m_fs, m_drp;

    // Frame recording for sequence checks.
    bit   rec_on = 0;
    int   rec_e[$];
    int   rec_p[$];
    int   rec_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_step();
        bit acc, launch;
        if (!rst_n) begin
            mq.delete();
            m_active = 0; m_age = 0;
            m_e = 0; m_p = 1; m_fs = 0; m_drp = 0;
            return;
        end
        acc    = in_valid && (mq.size() < DEPTH);
        launch = (mq.size() > 0) && (!m_active || m_age >= HOLD - 1);
        m_fs   = launch;
        m_drp  = acc && (int'(in_code) > MAXC);
        if (launch) begin
            m_e      = mq.pop_front();
            m_p      = (($countones(m_e) % 2) == 0) ^ inject_err;
            m_active = 1;
            m_age    = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age >= HOLD) m_active = 0;
        end
        if (acc && int'(in_code) <= MAXC) mq.push_back(int'(in_code));
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("model_E", 32'(E), 32'(m_e));
        chk("model_P", 32'(P), 32'(m_p));
        chk("model_strobe", 32'(frame_strobe), 32'(m_fs));
        chk("model_dropped", 32'(dropped), 32'(m_drp));
        chk("model_busy", 32'(busy), 32'(m_active || mq.size() > 0));
        chk("model_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        if (rec_on && frame_strobe) begin
            rec_e.push_back(int'(E));
            rec_p.push_back(int'(P));
            rec_cyc.push_back(cyc);
        end
    endtask

    typedef struct {
        bit       rst_n;
        bit       vld;
        bit [4:0] code;
        bit       inj;
        bit [4:0] e;
        bit       p;
        bit       fs;
        bit       rdy;
        bit       bsy;
        bit       drp;
    } vec_t;

    initial begin
        vec_t tbl[$];
        int   strobes;
        bit   acc;
        int   guard;
        int   exp_p6[6];

        rst_n = 0; in_valid = 0; in_code = '0; inject_err = 0;

        //            rst v  code   inj   E      P  fs rdy bsy drp
        tbl.push_back('{0, 0, 5'd0,  0, 5'd0, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 5'd0,  0, 5'd0, 1, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd0, 1, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 5'd1,  0, 5'd0, 1, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd1, 0, 1, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd1, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd1, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd1, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 5'd21, 0, 5'd1, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 5'd3,  0, 5'd1, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  1, 5'd3, 0, 1, 1, 1, 0});
        tbl.push_back('{1, 1, 5'd2,  0, 5'd3, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd3, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd3, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd2, 0, 1, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd2, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd2, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd2, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 5'd0,  0, 5'd2, 0, 0, 1, 0, 0});

        #2;
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; in_valid = tbl[i].vld;
            in_code = tbl[i].code; inject_err = tbl[i].inj;
            cycle();
            chk($sformatf("tbl%0d_E", i), 32'(E), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_P", i), 32'(P), 32'(tbl[i].p));
            chk($sformatf("tbl%0d_strobe", i), 32'(frame_strobe), 32'(tbl[i].fs));
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_dropped", i), 32'(dropped), 32'(tbl[i].drp));
        end
        in_valid = 0; inject_err = 0;

        // Six back-to-back pushes: the sixth must stall on a full FIFO first.
        rec_on = 1;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1; in_code = 5'(k);
            if (k == 6) chk("sixth_sees_full", 32'(in_ready), 32'd0);
            guard = 0;
            do begin
                acc = in_ready;
                cycle();
                guard++;
            end while (!acc && guard < 20);
            chk($sformatf("push%0d_accepted", k), 32'(acc), 32'd1);
        end
        in_valid = 0;
        for (int i = 0; i < 30; i++) cycle();
        rec_on = 0;
        exp_p6 = '{0, 0, 1, 0, 1, 1};
        chk("burst_frames", 32'(rec_e.size()), 32'd6);
        for (int i = 0; i < rec_e.size() && i < 6; i++) begin
            chk($sformatf("burst_E%0d", i), 32'(rec_e[i]), 32'(i + 1));
            chk($sformatf("burst_P%0d", i), 32'(rec_p[i]), 32'(exp_p6[i]));
            if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(rec_cyc[i] - rec_cyc[i-1]), 32'(HOLD));
        end

        // Reset mid-HOLD with two codes queued; a push on the reset edge is lost.
        for (int k = 7; k <= 9; k++) begin
            in_valid = 1; in_code = 5'(k);
            cycle();
        end
        in_valid = 1; in_code = 5'd10; rst_n = 0;
        cycle();
        chk("rst_E", 32'(E), 32'd0);
        chk("rst_P", 32'(P), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1; in_valid = 0;
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (frame_strobe) strobes++;
        end
        chk("post_rst_no_frames", 32'(strobes), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_code    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(21, 31))
                                                     : 5'($urandom_range(0, 20));
            inject_err = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transmissor_display.md
# transmissor_display

Transmitter-side block for the parity-protected 7-segment display link. It accepts 5-bit character codes from a producer through a valid/ready handshake and buffers them in a small FIFO. Each code is presented as an (E, P) frame with odd parity, held for a programmable number of cycles, so the existing display decoder shows a paced character sequence. The block also provides a parity-error injection hook so downstream validity checking can be exercised in-system.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- HOLD_CYCLES, 8: cycles each frame stays on E/P; ≥1
- MAX_CODE, 20: highest valid character code; codes above it are discarded
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_code  in  5  character code from producer
- in_valid  in  1  in_code valid
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- inject_err  in  1  when high at frame launch, P is inverted for that frame
- E  out  5  code bits to display (E1–E5)
- P  out  1  parity bit; E and P together carry an odd number of 1s unless injected
- frame_strobe  out  1  one-cycle pulse on the cycle a new frame first appears on E/P
- busy  out  1  FSM in HOLD or FIFO non-empty
- dropped  out  1  one-cycle pulse: an accepted code exceeded MAX_CODE and was discarded

## Operation
- Reset values: E=00000, P=1, frame_strobe=0, busy=0, dropped=0, in_ready=1, FIFO empty, FSM=IDLE, hold counter=0.
- in_ready = !full. It is registered-simple: no push while full, even if a pop happens the same cycle.
- Accepted code ≤ MAX_CODE is written to the FIFO tail. Accepted code > MAX_CODE is not stored; dropped pulses on the next cycle.
- Parity: P = ~^E (odd parity), XOR inject_err sampled at launch.
- FSM states:
  - IDLE
    - If FIFO non-empty: pop the head, register E and P, pulse frame_strobe, load counter with HOLD_CYCLES−1, go to HOLD.
    - Otherwise E/P keep the last frame, so the display keeps the last character.
  - HOLD
    - Counter decrements each cycle.
    - At counter==0 with FIFO non-empty: launch the next frame back-to-back, with no gap, and stay in HOLD.
    - At counter==0 with FIFO empty: go to IDLE, E/P unchanged.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged. A push into an empty FIFO is not visible to the FSM until the next cycle.
- Reset asserted mid-HOLD or mid-handshake: on that edge the FIFO is flushed, the FSM returns to IDLE and all outputs take reset values. A push on the reset edge is lost.

## Timing
- Latency from acceptance to display, with FSM idle and FIFO empty:
  - Code accepted at edge N is written at N.
  - It is launched at edge N+1, so E/P/frame_strobe are visible from N+1.
- Frame spacing with data queued: exactly HOLD_CYCLES cycles between frame_strobe pulses.
- HOLD_CYCLES=1 gives one frame per cycle at full throughput.
- dropped: asserted one cycle after the offending transfer, for one cycle.
- busy: combinational from the FSM state and the FIFO empty flag.

## Structure
- Shared package holds:
  - CODE_W=5 and the default MAX_CODE
  - the FSM state enum (IDLE, HOLD)
  - an odd-parity function used by this block and the display decoder
- One sub-module, fifo_codigos:
  - synchronous FIFO, parameters DEPTH and width CODE_W
  - outputs full/empty
  - read pointer and write pointer, each with a wrap bit
- The FSM, hold counter, parity and drop logic stay in transmissor_display.

## Test plan
All scenarios use DEPTH=4, HOLD_CYCLES=4.
- Reset: hold rst_n low 2 cycles → E=00000, P=1, in_ready=1, busy=0, frame_strobe=0.
- Single push 00001 at edge N → at N+1 E=00001, P=0, frame_strobe=1 for one cycle; back in IDLE after 4 cycles with E/P held.
- Six back-to-back pushes 00001..00110 → first five accepted, then in_ready=0 until the next pop. Frames appear 4 cycles apart in order, with P = 0,0,1,0,1,1.
- Push 10101 (21) → handshake completes, dropped pulses the next cycle, no frame_strobe, E/P unchanged.
- inject_err=1 while 00011 launches → E=00011, P=0 (even count). The next frame with inject_err=0 has correct parity.
- Reset mid-HOLD with 2 codes queued → outputs reach reset values on the reset edge; after release, no frames appear until a new push.
